// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: two write requesters and two read requesters share one DDR burst controller.
//   Write and read sides are independent round-robin arbiters; a grant drives start/addr/len,
//   per-beat enables/data are routed to the granted channel, and the winner gets a done pulse.
// Latency: req -> start is 1 cycle; finish -> done is 1 cycle; a zero-length request gives done 2 cycles after req.
// Backpressure: requests are level-held and not re-sampled mid-burst; the controller paces beats via wr_en/rd_en.
// Ports: wr_req*/rd_req* are the requester side ({ch1,ch0} packing, bit0 = ch0); wr_*/rd_* are the controller side;
//   err_timeout is sticky (bit0 write, bit1 read).
// Optional build macro ARB_TIMEOUT_EN adds a per-side burst watchdog of TIMEOUT_CYCLES cycles; when it is
//   undefined, err_timeout is tied to 0.

// One arbitration side: round-robin grant, controller command, burst FSM and done pulse.
//   Latency: start 1 cycle after req; done 1 cycle after finish.
//   Backpressure: none internally; beats are paced by the controller enable, which the top routes using sel.
module ddr_burst_arbiter_side #(
  parameter int ADDR_BITS      = 25,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [2*ADDR_BITS-1:0] req_addr,
  input  logic [2*ADDR_BITS-1:0] req_len,
  input  logic                   finish,
  output logic                   start,
  output logic [ADDR_BITS-1:0]   addr,
  output logic [ADDR_BITS-1:0]   len,
  output logic [1:0]             sel,
  output logic [1:0]             done,
  output logic                   err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]           state;
  logic                 last_grant;
  logic                 grant;
  logic                 zero_len;
  logic                 win;
  logic [ADDR_BITS-1:0] win_addr;
  logic [ADDR_BITS-1:0] win_len;
  logic                 timed_out;

  // Single requester wins outright; on a tie the channel that did not win last time goes.
  always_comb begin
    win = req[1];
    if (req == 2'b11) begin
      win = ~last_grant;
    end
    win_addr = win ? req_addr[2*ADDR_BITS-1:ADDR_BITS] : req_addr[ADDR_BITS-1:0];
    win_len  = win ? req_len[2*ADDR_BITS-1:ADDR_BITS]  : req_len[ADDR_BITS-1:0];
  end

  // Controller strobes only reach the requester while a burst is actually running.
  assign sel = (state == S_BUSY) ? {grant, ~grant} : 2'b00;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign timed_out = (state == S_BUSY) && !finish && (cnt == LIMIT);

  // Held at zero outside BUSY so every burst starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == S_BUSY) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (timed_out) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      zero_len   <= 1'b0;
      start      <= 1'b0;
      addr       <= '0;
      len        <= '0;
      done       <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 2'b00;
          if (|req) begin
            last_grant <= win;
            grant      <= win;
            if (win_len != '0) begin
              start <= 1'b1;
              addr  <= win_addr;
              len   <= win_len;
              state <= S_BUSY;
            end else begin
              // Nothing goes to the controller; spend one extra DONE cycle so done lands 2 cycles after req.
              zero_len <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (finish || timed_out) begin
            start <= 1'b0;
            addr  <= '0;
            len   <= '0;
            done  <= {grant, ~grant};
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (zero_len) begin
            zero_len <= 1'b0;
            done     <= {grant, ~grant};
          end else begin
            done  <= 2'b00;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

module ddr_burst_arbiter #(
  parameter int WRITE_DATA_BITS = 16,
  parameter int ADDR_BITS       = 25,
  parameter int TIMEOUT_CYCLES  = 200_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   wr_req,
  input  logic [2*ADDR_BITS-1:0]       wr_req_addr,
  input  logic [2*ADDR_BITS-1:0]       wr_req_len,
  input  logic [2*WRITE_DATA_BITS-1:0] wr_req_data,
  output logic [1:0]                   wr_req_en,
  output logic [1:0]                   wr_req_done,
  input  logic [1:0]                   rd_req,
  input  logic [2*ADDR_BITS-1:0]       rd_req_addr,
  input  logic [2*ADDR_BITS-1:0]       rd_req_len,
  output logic [1:0]                   rd_req_en,
  output logic [WRITE_DATA_BITS-1:0]   rd_req_data,
  output logic [1:0]                   rd_req_done,
  output logic                         wr_start,
  output logic [ADDR_BITS-1:0]         wr_addr,
  output logic [ADDR_BITS-1:0]         wr_len,
  input  logic                         wr_en,
  output logic [WRITE_DATA_BITS-1:0]   wr_data,
  input  logic                         wr_finish,
  output logic                         rd_start,
  output logic [ADDR_BITS-1:0]         rd_addr,
  output logic [ADDR_BITS-1:0]         rd_len,
  input  logic                         rd_en,
  input  logic [WRITE_DATA_BITS-1:0]   rd_data,
  input  logic                         rd_finish,
  output logic [1:0]                   err_timeout
);
  logic [1:0] wr_sel;
  logic [1:0] rd_sel;
  logic       wr_err;
  logic       rd_err;

  ddr_burst_arbiter_side #(
    .ADDR_BITS      (ADDR_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wr_side (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (wr_req),
    .req_addr (wr_req_addr),
    .req_len  (wr_req_len),
    .finish   (wr_finish),
    .start    (wr_start),
    .addr     (wr_addr),
    .len      (wr_len),
    .sel      (wr_sel),
    .done     (wr_req_done),
    .err      (wr_err)
  );

  ddr_burst_arbiter_side #(
    .ADDR_BITS      (ADDR_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_side (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rd_req),
    .req_addr (rd_req_addr),
    .req_len  (rd_req_len),
    .finish   (rd_finish),
    .start    (rd_start),
    .addr     (rd_addr),
    .len      (rd_len),
    .sel      (rd_sel),
    .done     (rd_req_done),
    .err      (rd_err)
  );

  assign wr_req_en   = wr_sel & {2{wr_en}};
  assign rd_req_en   = rd_sel & {2{rd_en}};
  // Read data is broadcast; readers qualify it with their rd_req_en bit.
  assign rd_req_data = rd_data;
  assign err_timeout = {rd_err, wr_err};

  // Write data follows the granted channel during BUSY and is zero otherwise.
  always_comb begin
    wr_data = '0;
    if (wr_sel[0]) begin
      wr_data = wr_req_data[WRITE_DATA_BITS-1:0];
    end else if (wr_sel[1]) begin
      wr_data = wr_req_data[2*WRITE_DATA_BITS-1:WRITE_DATA_BITS];
    end
  end
endmodule
